// File: rtl/bytewrite_ram_pkg.sv
// Shared definitions for the byte-write single-port RAM controller.
//   WM_* : read-during-write mode selectors for the WRITE_MODE parameter.
//   ram_state_t : clear-sequencer state (ST_CLEAR after reset, ST_RUN once the array is zeroed).
package bytewrite_ram_pkg;

    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;
    localparam int WM_NO_CHANGE   = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ram_state_t;

endpackage

// File: rtl/bytewrite_ram_col.sv
// One byte-enable column: storage array, write port and the registered read
// (stage-1) with the selected read-during-write behaviour.
// Optional macro BYTE_PARITY_EN adds one even-parity bit per stored word.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset (stage-1 register only)
//   wr_en    : write this column at addr
//   rd_en    : load stage-1 with the read result
//   addr     : word address
//   din      : column write data
//   rd_data  : stage-1 read data
//   rd_perr  : (BYTE_PARITY_EN only) parity mismatch of stage-1 word
module bytewrite_ram_col
    import bytewrite_ram_pkg::*;
#(
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int WRITE_MODE = WM_READ_FIRST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [COL_WIDTH-1:0]  din,
    output logic [COL_WIDTH-1:0]  rd_data
`ifdef BYTE_PARITY_EN
    ,
    output logic                  rd_perr
`endif
);

`ifdef BYTE_PARITY_EN
    localparam int SW = COL_WIDTH + 1;
`else
    localparam int SW = COL_WIDTH;
`endif

    logic [SW-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [SW-1:0] wr_word;
    logic [SW-1:0] rd_q;

`ifdef BYTE_PARITY_EN
    // Even parity: stored bit makes the XOR of the whole word zero.
    // Clearing writes din=0, so its parity bit is 0 as well.
    assign wr_word = {^din, din};
    assign rd_perr = ^rd_q;
`else
    assign wr_word = din;
`endif

    // Array has no reset; the clear sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_word;
        end
    end

    // Non-blocking write above means mem[addr] here is the old word (read-first);
    // write-first bypasses the incoming word instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else if (rd_en) begin
            if (WRITE_MODE == WM_WRITE_FIRST && wr_en) begin
                rd_q <= wr_word;
            end else begin
                rd_q <= mem[addr];
            end
        end
    end

    assign rd_data = rd_q[COL_WIDTH-1:0];

endmodule

// File: rtl/bytewrite_sp_ram_ctrl.sv
// Parametrised byte-write single-port RAM with selectable read-during-write
// mode, optional output register and a self-clearing init sequencer.
// Optional macro BYTE_PARITY_EN adds per-column parity and the parity_err port.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   ena        : port enable, ignored until init_done
//   we         : per-column write enable, qualified by ena
//   addr, din  : word address, write data (column c = din[c*COL_WIDTH +: COL_WIDTH])
//   dout       : read data
//   dout_vld   : one-cycle pulse marking a new read result on dout
//   init_done  : array clear finished, accesses accepted
//   parity_err : (BYTE_PARITY_EN only) per-column parity error, aligned with dout_vld
// Valid semantics: a read is accepted on every edge where init_done & ena
// (and, in NO_CHANGE mode, we==0); its result appears with dout_vld high for
// one cycle after 1 (OUT_REG=0) or 2 (OUT_REG=1) edges. There is no back-pressure.
module bytewrite_sp_ram_ctrl
    import bytewrite_ram_pkg::*;
#(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int WRITE_MODE = WM_READ_FIRST,
    parameter int OUT_REG    = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic [NUM_COL-1:0]             we,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [NUM_COL*COL_WIDTH-1:0]   din,
    output logic [NUM_COL*COL_WIDTH-1:0]   dout,
    output logic                           dout_vld,
    output logic                           init_done
`ifdef BYTE_PARITY_EN
    ,
    output logic [NUM_COL-1:0]             parity_err
`endif
);

    localparam int DW = NUM_COL * COL_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    ram_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  clearing;
    logic                  user_acc;
    logic                  rd_en;
    logic                  vld1_q;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [NUM_COL-1:0]    col_wr_en;
    logic [DW-1:0]         st1_data;
    logic [DW-1:0]         out_data;
    logic                  out_vld;
`ifdef BYTE_PARITY_EN
    logic [NUM_COL-1:0]    st1_perr;
    logic [NUM_COL-1:0]    out_perr;
`endif

    // Clear sequencer: one word per edge, leaves ST_CLEAR on the edge that writes the last word.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign init_done = (state_q == ST_RUN);
    assign clearing  = (state_q == ST_CLEAR);
    assign user_acc  = !clearing && ena;
    assign mem_addr  = clearing ? clr_addr_q : addr;
    // NO_CHANGE suppresses the read whenever any column is written.
    assign rd_en     = user_acc && ((WRITE_MODE != WM_NO_CHANGE) || (we == '0));

    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
        assign col_wr_en[c] = clearing || (user_acc && we[c]);

        bytewrite_ram_col #(
            .COL_WIDTH  (COL_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .WRITE_MODE (WRITE_MODE)
        ) u_col (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (col_wr_en[c]),
            .rd_en   (rd_en),
            .addr    (mem_addr),
            .din     (clearing ? {COL_WIDTH{1'b0}} : din[c*COL_WIDTH +: COL_WIDTH]),
            .rd_data (st1_data[c*COL_WIDTH +: COL_WIDTH])
`ifdef BYTE_PARITY_EN
            ,
            .rd_perr (st1_perr[c])
`endif
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1_q <= 1'b0;
        end else begin
            vld1_q <= rd_en;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DW-1:0] dout2_q;
        logic          vld2_q;
`ifdef BYTE_PARITY_EN
        logic [NUM_COL-1:0] perr2_q;
`endif
        // Stage-2 only captures real results so dout holds between reads.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout2_q <= '0;
                vld2_q  <= 1'b0;
`ifdef BYTE_PARITY_EN
                perr2_q <= '0;
`endif
            end else begin
                vld2_q <= vld1_q;
                if (vld1_q) begin
                    dout2_q <= st1_data;
`ifdef BYTE_PARITY_EN
                    perr2_q <= st1_perr;
`endif
                end
            end
        end
        assign out_data = dout2_q;
        assign out_vld  = vld2_q;
`ifdef BYTE_PARITY_EN
        assign out_perr = perr2_q;
`endif
    end else begin : g_no_out_reg
        assign out_data = st1_data;
        assign out_vld  = vld1_q;
`ifdef BYTE_PARITY_EN
        assign out_perr = st1_perr;
`endif
    end

    assign dout     = out_data;
    assign dout_vld = out_vld;
`ifdef BYTE_PARITY_EN
    // Non-sticky: only meaningful alongside a valid result.
    assign parity_err = out_perr & {NUM_COL{out_vld}};
`endif

endmodule
